// File: rtl/axi_lite_arbiter.sv
// Purpose : two-client AXI4-Lite master sequencer; grants one client and runs a single-beat read or write.
// Latency : cN_ready is a registered pulse in the grant cycle; AXI valids rise the next cycle; zero-wait done arrives 3 cycles after ready.
// Backpressure: a client holds valid until its ready pulse; AXI valids hold until the slave's ready; one transfer in flight.
// Ports   : clk/rst (sync, active high); c0_*/c1_* client request/response; axi_* AXI4-Lite master; debug_state = FSM code.
// Config  : define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise c0 has fixed priority.
module axi_lite_arbiter #(
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c0_valid,
    output logic        c0_ready,
    input  logic        c0_we,
    input  logic [31:0] c0_addr,
    input  logic [31:0] c0_wdata,
    input  logic [3:0]  c0_wstrb,
    output logic        c0_done,
    output logic [31:0] c0_rdata,
    output logic [1:0]  c0_resp,
    input  logic        c1_valid,
    output logic        c1_ready,
    input  logic        c1_we,
    input  logic [31:0] c1_addr,
    input  logic [31:0] c1_wdata,
    input  logic [3:0]  c1_wstrb,
    output logic        c1_done,
    output logic [31:0] c1_rdata,
    output logic [1:0]  c1_resp,
    output logic [31:0] axi_araddr,
    output logic        axi_arvalid,
    input  logic        axi_arready,
    output logic [2:0]  axi_arprot,
    input  logic [31:0] axi_rdata,
    input  logic [1:0]  axi_rresp,
    input  logic        axi_rvalid,
    output logic        axi_rready,
    output logic [31:0] axi_awaddr,
    output logic        axi_awvalid,
    input  logic        axi_awready,
    output logic [2:0]  axi_awprot,
    output logic [31:0] axi_wdata,
    output logic [3:0]  axi_wstrb,
    output logic        axi_wvalid,
    input  logic        axi_wready,
    input  logic [1:0]  axi_bresp,
    input  logic        axi_bvalid,
    output logic        axi_bready,
    output logic [2:0]  debug_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AR   = 3'd1,
        S_R    = 3'd2,
        S_AW_W = 3'd3,
        S_B    = 3'd4,
        S_RESP = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_c0_ready, r_c1_ready, r_c0_done, r_c1_done;
    logic        w_c0_ready_nxt, w_c1_ready_nxt, w_c0_done_nxt, w_c1_done_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic [1:0]  r_resp, w_resp_nxt;
    logic        r_gnt, w_gnt_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_addr, w_addr_nxt, r_wdata, w_wdata_nxt;
    logic [3:0]  r_wstrb, w_wstrb_nxt;
    logic        r_arvalid, r_rready, r_awvalid, r_wvalid, r_bready;
    logic        w_arvalid_nxt, w_rready_nxt, w_awvalid_nxt, w_wvalid_nxt, w_bready_nxt;
    logic        w_pick, w_grant;

`ifdef ARB_ROUND_ROBIN_EN
    // 1 = c1 wins the next contested grant; cleared on reset so c0 goes first.
    logic        r_rr_prio;
    assign w_pick = (c0_valid && c1_valid) ? r_rr_prio : ~c0_valid;
`else
    assign w_pick = ~c0_valid;
`endif

    // Grants are issued from an idle slot with no pulse outstanding, or straight out of RESP
    // so the ready pulse lands in the following IDLE cycle (4-cycle minimum period).
    assign w_grant = (c0_valid || c1_valid) &&
                     ((r_state == S_IDLE && !r_c0_ready && !r_c1_ready) || r_state == S_RESP);

    always_comb begin
        w_state_nxt    = r_state;
        w_c0_ready_nxt = 1'b0;
        w_c1_ready_nxt = 1'b0;
        w_c0_done_nxt  = 1'b0;
        w_c1_done_nxt  = 1'b0;
        w_rdata_nxt    = r_rdata;
        w_resp_nxt     = r_resp;
        w_gnt_nxt      = r_gnt;
        w_we_nxt       = r_we;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_wstrb_nxt    = r_wstrb;
        w_arvalid_nxt  = r_arvalid;
        w_rready_nxt   = r_rready;
        w_awvalid_nxt  = r_awvalid;
        w_wvalid_nxt   = r_wvalid;
        w_bready_nxt   = r_bready;
        case (r_state)
            S_IDLE: begin
                // A ready pulse in flight means the fields were latched last edge.
                if (r_c0_ready || r_c1_ready) begin
                    if (r_we) begin
                        w_state_nxt   = S_AW_W;
                        w_awvalid_nxt = 1'b1;
                        w_wvalid_nxt  = 1'b1;
                    end else begin
                        w_state_nxt   = S_AR;
                        w_arvalid_nxt = 1'b1;
                    end
                end
            end
            S_AR: begin
                if (axi_arready) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = S_R;
                end
            end
            S_R: begin
                if (axi_rvalid) begin
                    w_rready_nxt  = 1'b0;
                    w_rdata_nxt   = axi_rdata;
                    w_resp_nxt    = axi_rresp;
                    w_c0_done_nxt = ~r_gnt;
                    w_c1_done_nxt = r_gnt;
                    w_state_nxt   = S_RESP;
                end
            end
            S_AW_W: begin
                // Inside AW_W a low valid means that channel has already been accepted.
                if (axi_awready) w_awvalid_nxt = 1'b0;
                if (axi_wready)  w_wvalid_nxt  = 1'b0;
                if ((!r_awvalid || axi_awready) && (!r_wvalid || axi_wready)) begin
                    w_bready_nxt = 1'b1;
                    w_state_nxt  = S_B;
                end
            end
            S_B: begin
                if (axi_bvalid) begin
                    w_bready_nxt  = 1'b0;
                    w_resp_nxt    = axi_bresp;
                    w_c0_done_nxt = ~r_gnt;
                    w_c1_done_nxt = r_gnt;
                    w_state_nxt   = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_grant) begin
            w_c0_ready_nxt = ~w_pick;
            w_c1_ready_nxt = w_pick;
            w_gnt_nxt      = w_pick;
            w_we_nxt       = w_pick ? c1_we    : c0_we;
            w_addr_nxt     = w_pick ? c1_addr  : c0_addr;
            w_wdata_nxt    = w_pick ? c1_wdata : c0_wdata;
            w_wstrb_nxt    = w_pick ? c1_wstrb : c0_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_c0_ready <= 1'b0;
            r_c1_ready <= 1'b0;
            r_c0_done  <= 1'b0;
            r_c1_done  <= 1'b0;
            r_rdata    <= '0;
            r_resp     <= '0;
            r_gnt      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_c0_ready <= w_c0_ready_nxt;
            r_c1_ready <= w_c1_ready_nxt;
            r_c0_done  <= w_c0_done_nxt;
            r_c1_done  <= w_c1_done_nxt;
            r_rdata    <= w_rdata_nxt;
            r_resp     <= w_resp_nxt;
            r_gnt      <= w_gnt_nxt;
            r_we       <= w_we_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_wstrb    <= w_wstrb_nxt;
            r_arvalid  <= w_arvalid_nxt;
            r_rready   <= w_rready_nxt;
            r_awvalid  <= w_awvalid_nxt;
            r_wvalid   <= w_wvalid_nxt;
            r_bready   <= w_bready_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst)          r_rr_prio <= 1'b0;
        else if (w_grant) r_rr_prio <= ~w_pick;
    end
`endif

    assign c0_ready    = r_c0_ready;
    assign c1_ready    = r_c1_ready;
    assign c0_done     = r_c0_done;
    assign c1_done     = r_c1_done;
    assign c0_rdata    = r_rdata;
    assign c1_rdata    = r_rdata;
    assign c0_resp     = r_resp;
    assign c1_resp     = r_resp;
    assign axi_araddr  = r_addr;
    assign axi_awaddr  = r_addr;
    assign axi_wdata   = r_wdata;
    assign axi_wstrb   = r_wstrb;
    assign axi_arvalid = r_arvalid;
    assign axi_rready  = r_rready;
    assign axi_awvalid = r_awvalid;
    assign axi_wvalid  = r_wvalid;
    assign axi_bready  = r_bready;
    assign axi_arprot  = PROT;
    assign axi_awprot  = PROT;
    assign debug_state = r_state;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Purpose : self-checking bench for axi_lite_arbiter with a latency-programmable AXI4-Lite slave.
// Latency : inputs driven 1 time unit after the rising edge, outputs sampled there too; slave acts on the falling edge.
// Backpressure: slave ready/valid delays are set per scenario through ar_lat/r_lat/aw_lat/w_lat/b_lat.
module tb_axi_lite_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        c0_valid = 1'b0, c0_we = 1'b0, c1_valid = 1'b0, c1_we = 1'b0;
    logic [31:0] c0_addr = '0, c0_wdata = '0, c1_addr = '0, c1_wdata = '0;
    logic [3:0]  c0_wstrb = '0, c1_wstrb = '0;
    logic        c0_ready, c1_ready, c0_done, c1_done;
    logic [31:0] c0_rdata, c1_rdata;
    logic [1:0]  c0_resp, c1_resp;
    logic [31:0] axi_araddr, axi_awaddr, axi_wdata;
    logic [2:0]  axi_arprot, axi_awprot, debug_state;
    logic [3:0]  axi_wstrb;
    logic        axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready;
    logic        axi_arready = 1'b0, axi_rvalid = 1'b0, axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
    logic [31:0] axi_rdata = '0;
    logic [1:0]  axi_rresp = '0, axi_bresp = '0;

    axi_lite_arbiter #(.PROT(3'b000)) dut (
        .clk(clk), .rst(rst),
        .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_we(c0_we), .c0_addr(c0_addr),
        .c0_wdata(c0_wdata), .c0_wstrb(c0_wstrb), .c0_done(c0_done), .c0_rdata(c0_rdata), .c0_resp(c0_resp),
        .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_we(c1_we), .c1_addr(c1_addr),
        .c1_wdata(c1_wdata), .c1_wstrb(c1_wstrb), .c1_done(c1_done), .c1_rdata(c1_rdata), .c1_resp(c1_resp),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arprot(axi_arprot),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awprot(axi_awprot),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .debug_state(debug_state)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t sb[$];

    // ---------------- AXI4-Lite slave model ----------------
    int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
    int ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
    logic [31:0] s_rdata = 32'hDEADBEEF;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
    bit rd_pend = 0, aw_got = 0, w_got = 0;
    bit hs_ar = 0, hs_r = 0, hs_aw = 0, hs_w = 0, hs_b = 0;

    always @(negedge clk) begin
        if (rst) begin
            axi_arready = 0; axi_rvalid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0;
            rd_pend = 0; aw_got = 0; w_got = 0;
            hs_ar = 0; hs_r = 0; hs_aw = 0; hs_w = 0; hs_b = 0;
            ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        end else begin
            if (hs_ar) begin rd_pend = 1; r_cnt = 0; end
            if (hs_r)  rd_pend = 0;
            if (hs_aw) aw_got = 1;
            if (hs_w)  w_got = 1;
            if (hs_b)  begin aw_got = 0; w_got = 0; b_cnt = 0; end
            if (axi_arvalid) begin
                if (ar_cnt >= ar_lat) axi_arready = 1; else begin axi_arready = 0; ar_cnt++; end
            end else begin axi_arready = 0; ar_cnt = 0; end
            if (axi_awvalid) begin
                if (aw_cnt >= aw_lat) axi_awready = 1; else begin axi_awready = 0; aw_cnt++; end
            end else begin axi_awready = 0; aw_cnt = 0; end
            if (axi_wvalid) begin
                if (w_cnt >= w_lat) axi_wready = 1; else begin axi_wready = 0; w_cnt++; end
            end else begin axi_wready = 0; w_cnt = 0; end
            if (rd_pend) begin
                if (r_cnt >= r_lat) begin axi_rvalid = 1; axi_rdata = s_rdata; axi_rresp = s_rresp; end
                else begin axi_rvalid = 0; r_cnt++; end
            end else axi_rvalid = 0;
            if (aw_got && w_got) begin
                if (b_cnt >= b_lat) begin axi_bvalid = 1; axi_bresp = s_bresp; end
                else begin axi_bvalid = 0; b_cnt++; end
            end else axi_bvalid = 0;
            hs_ar = axi_arvalid && axi_arready;
            hs_r  = axi_rvalid  && axi_rready;
            hs_aw = axi_awvalid && axi_awready;
            hs_w  = axi_wvalid  && axi_wready;
            hs_b  = axi_bvalid  && axi_bready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request from client id; elat = expected ready-to-done cycles (-1 = not checked).
    task automatic run_single(input int id, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] st, input logic [31:0] erd, input logic [1:0] ersp,
                              input int elat, input string nm);
        exp_t e;
        bit   got;
        bit   other_done;
        int   t;
        e.id = id; e.rdata = erd; e.resp = ersp;
        sb.push_back(e);
        if (id == 0) begin c0_we = we; c0_addr = addr; c0_wdata = wd; c0_wstrb = st; c0_valid = 1; end
        else         begin c1_we = we; c1_addr = addr; c1_wdata = wd; c1_wstrb = st; c1_valid = 1; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (id == 0) ? c0_ready : c1_ready;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL %s_grant: ready=0 after 20 cycles, required 1", nm);
            c0_valid = 0; c1_valid = 0;
            void'(sb.pop_back());
            return;
        end
        n_vec++;
        if (((id == 0) ? c1_ready : c0_ready) !== 1'b0) begin
            n_err++; $display("FAIL %s_other_ready: got 1, required 0", nm);
        end
        if (id == 0) c0_valid = 0; else c1_valid = 0;
        tick();
        n_vec++;
        if ((we ? (axi_awvalid & axi_wvalid) : axi_arvalid) !== 1'b1) begin
            n_err++; $display("FAIL %s_axi_valid_t1: got 0, required 1", nm);
        end
        t = 1; got = 0; other_done = 0;
        while (t < 60 && !got) begin
            if (((id == 0) ? c1_done : c0_done) === 1'b1) other_done = 1;
            if (((id == 0) ? c0_done : c1_done) === 1'b1) got = 1;
            else begin tick(); t++; end
        end
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL %s_done: no done within 60 cycles", nm);
            void'(sb.pop_front());
            return;
        end
        if (elat >= 0) begin
            n_vec++;
            if (t !== elat) begin n_err++; $display("FAIL %s_latency: got %0d cycles, required %0d", nm, t, elat); end
        end
        e = sb.pop_front();
        n_vec++;
        if (((id == 0) ? c0_resp : c1_resp) !== e.resp) begin
            n_err++; $display("FAIL %s_resp: got %b, required %b", nm, (id == 0) ? c0_resp : c1_resp, e.resp);
        end
        if (!we) begin
            n_vec++;
            if (((id == 0) ? c0_rdata : c1_rdata) !== e.rdata) begin
                n_err++; $display("FAIL %s_rdata: got %h, required %h", nm, (id == 0) ? c0_rdata : c1_rdata, e.rdata);
            end
        end
        n_vec++;
        if (other_done) begin n_err++; $display("FAIL %s_other_done: got 1, required 0", nm); end
        tick();
        n_vec++;
        if (debug_state !== 3'd0) begin n_err++; $display("FAIL %s_idle_after: got %0d, required 0", nm, debug_state); end
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); tick();
        n_vec++;
        if (debug_state !== 3'd0) begin n_err++; $display("FAIL reset_state: got %0d, required 0", debug_state); end
        n_vec++;
        if ({c0_ready, c1_ready, c0_done, c1_done} !== 4'b0) begin
            n_err++; $display("FAIL reset_client_hs: got %b, required 0000", {c0_ready, c1_ready, c0_done, c1_done});
        end
        n_vec++;
        if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== 5'b0) begin
            n_err++; $display("FAIL reset_axi_hs: got %b, required 00000",
                              {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready});
        end
        n_vec++;
        if ({axi_araddr, axi_awaddr, axi_wdata, axi_wstrb} !== 100'b0) begin
            n_err++; $display("FAIL reset_axi_fields: got %h %h %h %h, required 0", axi_araddr, axi_awaddr, axi_wdata, axi_wstrb);
        end
        n_vec++;
        if ({c0_rdata, c0_resp, c1_rdata, c1_resp} !== 68'b0) begin
            n_err++; $display("FAIL reset_rdata_resp: got %h/%b, required 0", c0_rdata, c0_resp);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_read_basic();
        s_rdata = 32'hDEADBEEF; s_rresp = 2'b00;
        run_single(0, 1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hDEADBEEF, 2'b00, 3, "c0_read");
        s_rdata = 32'h1234_5678;
        run_single(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 32'h1234_5678, 2'b00, 3, "c1_read");
        run_single(0, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, 3, "c0_write");
    endtask

    task automatic test_write_skew();
        exp_t e;
        bit   got;
        aw_lat = 2; w_lat = 0; b_lat = 0; s_bresp = 2'b00;
        e.id = 1; e.rdata = 32'h0; e.resp = 2'b00;
        sb.push_back(e);
        c1_we = 1; c1_addr = 32'h8; c1_wdata = 32'hA5A5_0001; c1_wstrb = 4'b0011; c1_valid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = c1_ready; end
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL wskew_grant: c1_ready=0 after 20 cycles, required 1");
            c1_valid = 0; void'(sb.pop_back()); aw_lat = 0; return;
        end
        c1_valid = 0;
        tick();
        n_vec++;
        if ({axi_awvalid, axi_wvalid, axi_awaddr, axi_wdata, axi_wstrb} !== {2'b11, 32'h8, 32'hA5A5_0001, 4'b0011}) begin
            n_err++; $display("FAIL wskew_t1: got v=%b%b a=%h d=%h s=%b, required 11 8 a5a50001 0011",
                              axi_awvalid, axi_wvalid, axi_awaddr, axi_wdata, axi_wstrb);
        end
        tick();
        n_vec++;
        if ({axi_awvalid, axi_wvalid, axi_bready} !== 3'b100) begin
            n_err++; $display("FAIL wskew_wdrop: got aw/w/b=%b, required 100", {axi_awvalid, axi_wvalid, axi_bready});
        end
        tick();
        n_vec++;
        if ({axi_awvalid, axi_bready} !== 2'b10) begin
            n_err++; $display("FAIL wskew_awhold: got aw/b=%b, required 10", {axi_awvalid, axi_bready});
        end
        tick();
        n_vec++;
        if ({axi_awvalid, axi_bready} !== 2'b01) begin
            n_err++; $display("FAIL wskew_bready: got aw/b=%b, required 01", {axi_awvalid, axi_bready});
        end
        tick();
        n_vec++;
        if ({c1_done, c0_done} !== 2'b10) begin
            n_err++; $display("FAIL wskew_done: got c1/c0=%b, required 10", {c1_done, c0_done});
        end
        e = sb.pop_front();
        n_vec++;
        if (c1_resp !== e.resp) begin n_err++; $display("FAIL wskew_bresp: got %b, required %b", c1_resp, e.resp); end
        aw_lat = 0;
        tick();
    endtask

    task automatic test_contend();
        exp_t e;
        bit   got;
        int   who, last_cyc;
        int   seq [5];
`ifdef ARB_ROUND_ROBIN_EN
        seq = '{0, 1, 0, 1, 0};
`else
        seq = '{0, 0, 0, 0, 1};
`endif
        for (int k = 0; k < 5; k++) begin
            e.id = seq[k]; e.rdata = 32'hDEADBEEF; e.resp = 2'b00;
            sb.push_back(e);
        end
        s_rdata = 32'hDEADBEEF;
        c0_we = 0; c0_addr = 32'h100; c1_we = 0; c1_addr = 32'h200;
        c0_valid = 1; c1_valid = 1;
        last_cyc = 0;
        for (int k = 0; k < 5; k++) begin
            got = 0;
            for (int i = 0; i < 20 && !got; i++) begin tick(); got = c0_ready | c1_ready; end
            n_vec++;
            if (!got) begin
                n_err++; $display("FAIL contend_grant%0d: no ready within 20 cycles", k);
                c0_valid = 0; c1_valid = 0; sb.delete(); return;
            end
            who = c1_ready ? 1 : 0;
            e = sb.pop_front();
            n_vec++;
            if ((c0_ready & c1_ready) !== 1'b0 || who != e.id) begin
                n_err++; $display("FAIL contend_winner%0d: got c0=%b c1=%b, required client %0d", k, c0_ready, c1_ready, e.id);
            end
            if (k > 0 && k < 4) begin
                n_vec++;
                if (cyc - last_cyc != 4) begin
                    n_err++; $display("FAIL contend_period%0d: got %0d cycles, required 4", k, cyc - last_cyc);
                end
            end
            last_cyc = cyc;
            if (who == 0) c0_valid = 0; else c1_valid = 0;
            got = 0;
            for (int i = 0; i < 30 && !got; i++) begin tick(); got = (who == 0) ? c0_done : c1_done; end
            n_vec++;
            if (!got || ((who == 0) ? c1_done : c0_done) !== 1'b0) begin
                n_err++; $display("FAIL contend_done%0d: winner done=%b, other done=%b, required 1/0", k, got,
                                  (who == 0) ? c1_done : c0_done);
            end
            if (k < 3) begin
                if (who == 0) c0_valid = 1; else c1_valid = 1;
            end
        end
        tick();
    endtask

    task automatic test_slverr();
        s_rresp = 2'b10; s_rdata = 32'h0BAD_0BAD;
        run_single(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'h0BAD_0BAD, 2'b10, 3, "slverr");
        s_rresp = 2'b00; s_rdata = 32'hDEADBEEF;
    endtask

    task automatic test_reset_mid();
        bit got;
        bit done_seen;
        r_lat = 20;
        c0_we = 0; c0_addr = 32'h0000_4000; c0_valid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = c0_ready; end
        c0_valid = 0;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = axi_rready; end
        n_vec++;
        if (!got) begin n_err++; $display("FAIL rstmid_reach_r: rready=0 after 20 cycles, required 1"); end
        tick();
        rst = 1;
        tick();
        rst = 0;
        n_vec++;
        if ({axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready} !== 5'b0 || debug_state !== 3'd0) begin
            n_err++; $display("FAIL rstmid_clear: got hs=%b state=%0d, required 00000 0",
                              {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, debug_state);
        end
        done_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (c0_done | c1_done) done_seen = 1;
            tick();
        end
        n_vec++;
        if (done_seen) begin n_err++; $display("FAIL rstmid_no_done: got a done pulse, required none"); end
        r_lat = 0;
        s_rdata = 32'h7777_0001;
        run_single(0, 1'b0, 32'h0000_4004, 32'h0, 4'h0, 32'h7777_0001, 2'b00, 3, "rstmid_fresh");
    endtask

    task automatic test_stall();
        exp_t e;
        bit   got, bad;
        ar_lat = 10;
        s_rdata = 32'h5555_AAAA;
        e.id = 0; e.rdata = 32'h5555_AAAA; e.resp = 2'b00; sb.push_back(e);
        e.id = 1; sb.push_back(e);
        c0_we = 0; c0_addr = 32'h0000_2000; c0_valid = 1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin tick(); got = c0_ready; end
        c0_valid = 0;
        c1_we = 0; c1_addr = 32'h0000_3000; c1_valid = 1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (axi_arvalid !== 1'b1 || axi_araddr !== 32'h0000_2000 || c1_ready !== 1'b0) bad = 1;
        end
        n_vec++;
        if (!got || bad) begin
            n_err++; $display("FAIL stall_hold: granted=%b, stable=%b, required 1/1", got, !bad);
        end
        got = 0; bad = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            got = c0_done;
            if (c1_ready) bad = 1;
        end
        e = sb.pop_front();
        n_vec++;
        if (!got || bad || c0_rdata !== e.rdata) begin
            n_err++; $display("FAIL stall_c0_done: done=%b early_c1_ready=%b rdata=%h, required 1/0/%h", got, bad, c0_rdata, e.rdata);
        end
        ar_lat = 0;
        tick();
        n_vec++;
        if (c1_ready !== 1'b1) begin n_err++; $display("FAIL stall_c1_grant: got %b, required 1", c1_ready); end
        c1_valid = 0;
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin tick(); got = c1_done; end
        e = sb.pop_front();
        n_vec++;
        if (!got || c1_rdata !== e.rdata || c1_resp !== e.resp) begin
            n_err++; $display("FAIL stall_c1_done: done=%b rdata=%h resp=%b, required 1/%h/%b", got, c1_rdata, c1_resp, e.rdata, e.resp);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_skew();
        test_contend();
        test_slverr();
        test_reset_mid();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
